// File: rtl/cam_reg_table.sv
// Register-based CAM for the L2 learning/lookup path: 2-stage compare pipeline,
// free-entry finder and occupancy count. Entry aging is built when CAM_AGING_EN is defined.
module cam_reg_table #(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     write_addr,
  input  logic [DATA_WIDTH-1:0]     write_data,
  input  logic                      write_delete,
  input  logic                      write_enable,
  output logic                      write_busy,
  input  logic [DATA_WIDTH-1:0]     compare_data,
  input  logic                      compare_valid,
  output logic                      match_valid,
  output logic [2**ADDR_WIDTH-1:0]  match_many,
  output logic [2**ADDR_WIDTH-1:0]  match_single,
  output logic [ADDR_WIDTH-1:0]     match_addr,
  output logic                      match,
  output logic [ADDR_WIDTH-1:0]     free_addr,
  output logic                      free_valid,
  output logic [ADDR_WIDTH:0]       entry_count,
  input  logic                      age_tick
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_key [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      w_valid_nxt;
  logic [DEPTH-1:0]      w_cmp;
  logic                  w_busy;
  logic                  w_wr_ok;

  logic                  r_s1_valid;
  logic [DEPTH-1:0]      r_s1_many;
  logic                  r_match_valid;
  logic [DEPTH-1:0]      r_match_many;
  logic [DEPTH-1:0]      r_match_single;
  logic [ADDR_WIDTH-1:0] r_match_addr;
  logic                  r_match;
  logic [DEPTH-1:0]      w_single;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_found;

  logic [ADDR_WIDTH-1:0] r_free_addr;
  logic                  r_free_valid;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH-1:0] w_free_addr;
  logic                  w_free_valid;
  logic [ADDR_WIDTH:0]   w_count;

  assign w_wr_ok = write_enable && !w_busy;

  always_comb begin
    w_cmp = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cmp[i] = compare_valid && r_valid[i] && (r_key[i] == compare_data);
    end
  end

`ifdef CAM_AGING_EN
  // state  | meaning
  // IDLE   | normal operation, writes accepted
  // SWEEP  | aging walk over one entry per cycle, writes refused
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_sweep_idx;
  logic [DEPTH-1:0]      r_hit;
  logic [DEPTH-1:0]      w_hit_nxt;

  assign w_busy = (r_state == ST_SWEEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sweep_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (age_tick) begin
            r_state     <= ST_SWEEP;
            r_sweep_idx <= '0;
          end
        end
        ST_SWEEP: begin
          r_sweep_idx <= r_sweep_idx + ADDR_WIDTH'(1);
          if (r_sweep_idx == ADDR_WIDTH'(DEPTH - 1)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_hit <= '0;
    else     r_hit <= w_hit_nxt;
  end
`else
  logic w_unused;
  assign w_unused = age_tick;
  assign w_busy   = 1'b0;
`endif

  always_comb begin
    w_valid_nxt = r_valid;
`ifdef CAM_AGING_EN
    w_hit_nxt = r_hit | w_cmp;
    // a lookup hitting the visited entry in the same cycle keeps it alive
    if (r_state == ST_SWEEP) begin
      if (r_valid[r_sweep_idx] && !r_hit[r_sweep_idx] && !w_cmp[r_sweep_idx])
        w_valid_nxt[r_sweep_idx] = 1'b0;
      else
        w_hit_nxt[r_sweep_idx] = w_cmp[r_sweep_idx];
    end
`endif
    if (w_wr_ok) begin
      w_valid_nxt[write_addr] = !write_delete;
`ifdef CAM_AGING_EN
      if (!write_delete) w_hit_nxt[write_addr] = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok && !write_delete) r_key[write_addr] <= write_data;
  end

  always_comb begin
    w_single = '0;
    w_addr   = '0;
    w_found  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_s1_many[i] && !w_found) begin
        w_found     = 1'b1;
        w_single[i] = 1'b1;
        w_addr      = i[ADDR_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_free_addr  = '0;
    w_free_valid = 1'b0;
    w_count      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + (ADDR_WIDTH+1)'(r_valid[i]);
      if (!r_valid[i] && !w_free_valid) begin
        w_free_valid = 1'b1;
        w_free_addr  = i[ADDR_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid        <= '0;
      r_s1_valid     <= 1'b0;
      r_s1_many      <= '0;
      r_match_valid  <= 1'b0;
      r_match_many   <= '0;
      r_match_single <= '0;
      r_match_addr   <= '0;
      r_match        <= 1'b0;
      r_free_addr    <= '0;
      r_free_valid   <= 1'b1;
      r_count        <= '0;
    end else begin
      r_valid       <= w_valid_nxt;
      r_s1_valid    <= compare_valid;
      r_s1_many     <= w_cmp;
      r_match_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_match_many   <= r_s1_many;
        r_match_single <= w_single;
        r_match_addr   <= w_addr;
        r_match        <= w_found;
      end
      r_free_addr  <= w_free_addr;
      r_free_valid <= w_free_valid;
      r_count      <= w_count;
    end
  end

  assign write_busy   = w_busy;
  assign match_valid  = r_match_valid;
  assign match_many   = r_match_many;
  assign match_single = r_match_single;
  assign match_addr   = r_match_addr;
  assign match        = r_match;
  assign free_addr    = r_free_addr;
  assign free_valid   = r_free_valid;
  assign entry_count  = r_count;

endmodule

// File: tb/tb_cam_reg_table.sv
// Self-checking bench for cam_reg_table: directed scenarios plus random traffic
// against a table-level reference model. Honours CAM_AGING_EN like the design.
module tb_cam_reg_table;
  localparam int DW    = 48;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [AW-1:0]   write_addr = '0;
  logic [DW-1:0]   write_data = '0;
  logic            write_delete = 1'b0;
  logic            write_enable = 1'b0;
  logic            write_busy;
  logic [DW-1:0]   compare_data = '0;
  logic            compare_valid = 1'b0;
  logic            match_valid;
  logic [DEPTH-1:0] match_many;
  logic [DEPTH-1:0] match_single;
  logic [AW-1:0]   match_addr;
  logic            match;
  logic [AW-1:0]   free_addr;
  logic            free_valid;
  logic [AW:0]     entry_count;
  logic            age_tick = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  cam_reg_table #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .write_addr(write_addr), .write_data(write_data), .write_delete(write_delete),
    .write_enable(write_enable), .write_busy(write_busy),
    .compare_data(compare_data), .compare_valid(compare_valid),
    .match_valid(match_valid), .match_many(match_many), .match_single(match_single),
    .match_addr(match_addr), .match(match),
    .free_addr(free_addr), .free_valid(free_valid), .entry_count(entry_count),
    .age_tick(age_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // reference model: table contents, lookup results in flight, aging walk
  typedef struct { bit v; logic [DEPTH-1:0] many; } res_t;
  res_t             q[$];
  logic [DW-1:0]    m_key   [DEPTH];
  bit               m_valid [DEPTH];
  bit               m_hit   [DEPTH];
  bit               m_sweep = 1'b0;
  int               m_idx   = 0;
  bit               e_mv = 1'b0, e_match = 1'b0, e_free_valid = 1'b1, e_busy = 1'b0;
  logic [DEPTH-1:0] e_many = '0, e_single = '0;
  int               e_addr = 0, e_count = 0, e_free_addr = 0;
  logic [DW-1:0]    pool [6];

  task automatic tick();
    logic [DEPTH-1:0] cm;
    int pc, fa;
    bit fv, was_sweep, inval;
    res_t r;
    cm = '0; pc = 0; fa = 0; fv = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (compare_valid && m_valid[i] && m_key[i] == compare_data) cm[i] = 1'b1;
      if (m_valid[i]) pc++;
      else if (!fv) begin fv = 1'b1; fa = i; end
    end
    was_sweep = m_sweep;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 1'b0; m_hit[i] = 1'b0; end
      m_sweep = 1'b0; m_idx = 0; q.delete();
      e_mv = 1'b0; e_many = '0; e_single = '0; e_addr = 0; e_match = 1'b0;
      e_count = 0; e_free_addr = 0; e_free_valid = 1'b1;
    end else begin
      e_count = pc; e_free_addr = fa; e_free_valid = fv;
      q.push_back('{compare_valid, cm});
      if (q.size() >= 2) begin
        r = q.pop_front();
        e_mv = r.v;
        if (r.v) begin
          e_many = r.many; e_match = (r.many != '0); e_single = '0; e_addr = 0;
          for (int i = DEPTH-1; i >= 0; i--) if (r.many[i]) e_addr = i;
          if (e_match) e_single[e_addr] = 1'b1;
        end
      end
`ifdef CAM_AGING_EN
      inval = m_sweep && m_valid[m_idx] && !m_hit[m_idx] && !cm[m_idx];
      for (int i = 0; i < DEPTH; i++) if (cm[i]) m_hit[i] = 1'b1;
      if (m_sweep) begin
        if (inval) m_valid[m_idx] = 1'b0;
        else m_hit[m_idx] = cm[m_idx];
        m_idx++;
        if (m_idx == DEPTH) m_sweep = 1'b0;
      end else if (age_tick) begin
        m_sweep = 1'b1; m_idx = 0;
      end
`endif
      if (write_enable && !was_sweep) begin
        if (write_delete) m_valid[write_addr] = 1'b0;
        else begin
          m_valid[write_addr] = 1'b1; m_key[write_addr] = write_data; m_hit[write_addr] = 1'b1;
        end
      end
    end
    e_busy = m_sweep;
    @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input bit del);
    write_enable = 1'b1; write_addr = a[AW-1:0]; write_data = d; write_delete = del;
    tick();
    write_enable = 1'b0; write_delete = 1'b0;
  endtask

  task automatic cmp(input logic [DW-1:0] d);
    compare_valid = 1'b1; compare_data = d;
    tick();
    compare_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_total++;
    if ({match_valid, match, match_addr, match_many, match_single} !== '0) begin
      n_bad++; $display("FAIL reset_match got=%0b/%0b/%0d/%h/%h exp=all zero",
                        match_valid, match, match_addr, match_many, match_single);
    end
    n_total++;
    if (entry_count !== 6'd0 || free_valid !== 1'b1 || free_addr !== 5'd0) begin
      n_bad++; $display("FAIL reset_status got count=%0d fv=%0b fa=%0d exp 0/1/0", entry_count, free_valid, free_addr);
    end
    n_total++;
    if (write_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b exp=0", write_busy); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] k;
    k = 48'h0011_2233_4455;
    wr(3, k, 1'b0);
    cmp(k);
    tick();
    n_total++;
    if (match_valid !== 1'b1 || match !== 1'b1 || match_addr !== 5'd3) begin
      n_bad++; $display("FAIL basic_match got mv=%0b m=%0b addr=%0d exp 1/1/3", match_valid, match, match_addr);
    end
    n_total++;
    if (match_many !== 32'h0000_0008) begin n_bad++; $display("FAIL basic_many got=%h exp=00000008", match_many); end
    n_total++;
    if (entry_count !== 6'd1 || free_addr !== 5'd0) begin
      n_bad++; $display("FAIL basic_status got count=%0d fa=%0d exp 1/0", entry_count, free_addr);
    end
  endtask

  task automatic test_multi();
    logic [DW-1:0] k;
    k = 48'h0011_2233_4455;
    wr(3, k, 1'b1);
    wr(5, k, 1'b0);
    wr(9, k, 1'b0);
    cmp(k);
    tick();
    n_total++;
    if (match_many !== 32'h0000_0220 || match_single !== 32'h0000_0020 || match_addr !== 5'd5) begin
      n_bad++; $display("FAIL multi_priority got many=%h single=%h addr=%0d exp 00000220/00000020/5",
                        match_many, match_single, match_addr);
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] base;
    base = 48'hA000_0000_0000;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) wr(i, base + DW'(i), 1'b0);
    tick(); tick();
    n_total++;
    if (entry_count !== 6'd32 || free_valid !== 1'b0 || free_addr !== 5'd0) begin
      n_bad++; $display("FAIL fill_full got count=%0d fv=%0b fa=%0d exp 32/0/0", entry_count, free_valid, free_addr);
    end
    wr(17, '0, 1'b1);
    n_total++;
    if (entry_count !== 6'd32) begin n_bad++; $display("FAIL fill_lag got count=%0d exp=32", entry_count); end
    tick();
    n_total++;
    if (entry_count !== 6'd31 || free_valid !== 1'b1 || free_addr !== 5'd17) begin
      n_bad++; $display("FAIL fill_delete got count=%0d fv=%0b fa=%0d exp 31/1/17", entry_count, free_valid, free_addr);
    end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] ka;
    ka = 48'h0BAD_F00D_0001;
    write_enable = 1'b1; write_addr = 5'd2; write_data = ka; write_delete = 1'b0;
    compare_valid = 1'b1; compare_data = ka;
    tick();
    write_enable = 1'b0;
    tick();
    compare_valid = 1'b0;
    n_total++;
    if (match_valid !== 1'b1 || match !== 1'b0) begin
      n_bad++; $display("FAIL same_cycle_old got mv=%0b m=%0b exp 1/0", match_valid, match);
    end
    tick();
    n_total++;
    if (match_valid !== 1'b1 || match !== 1'b1 || match_addr !== 5'd2) begin
      n_bad++; $display("FAIL same_cycle_new got mv=%0b m=%0b addr=%0d exp 1/1/2", match_valid, match, match_addr);
    end
  endtask

  task automatic test_miss_reset();
    cmp(48'h7777_0000_1234);
    tick();
    n_total++;
    if (match_valid !== 1'b1 || match !== 1'b0 || match_addr !== 5'd0 || match_many !== '0) begin
      n_bad++; $display("FAIL miss got mv=%0b m=%0b addr=%0d many=%h exp 1/0/0/0", match_valid, match, match_addr, match_many);
    end
    cmp(48'h0BAD_F00D_0001);
    rst = 1'b1; tick(); rst = 1'b0;
    n_total++;
    if (match_valid !== 1'b0 || entry_count !== 6'd0) begin
      n_bad++; $display("FAIL reset_flush got mv=%0b count=%0d exp 0/0", match_valid, entry_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    for (int k = 0; k < 6; k++) begin
      t = $urandom();
      pool[k] = {16'h5A00 + 16'(k), t};
    end
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      write_enable  = ($urandom_range(0, 1) == 1);
      write_delete  = ($urandom_range(0, 3) == 0);
      write_addr    = AW'($urandom_range(0, DEPTH-1));
      write_data    = pool[$urandom_range(0, 5)];
      compare_valid = ($urandom_range(0, 9) < 7);
      compare_data  = ($urandom_range(0, 7) == 0) ? 48'hFFFF_0000_0000 : pool[$urandom_range(0, 5)];
      age_tick      = ($urandom_range(0, 63) == 0);
      tick();
      n_total++;
      if ({match_valid, match, match_addr, match_many, match_single} !==
          {e_mv, e_match, e_addr[AW-1:0], e_many, e_single}) begin
        n_bad++; $display("FAIL rnd_result cyc=%0d got mv=%0b m=%0b a=%0d many=%h single=%h exp mv=%0b m=%0b a=%0d many=%h single=%h",
                          c, match_valid, match, match_addr, match_many, match_single,
                          e_mv, e_match, e_addr, e_many, e_single);
      end
      n_total++;
      if ({entry_count, free_valid, free_addr, write_busy} !==
          {e_count[AW:0], e_free_valid, e_free_addr[AW-1:0], e_busy}) begin
        n_bad++; $display("FAIL rnd_status cyc=%0d got cnt=%0d fv=%0b fa=%0d busy=%0b exp cnt=%0d fv=%0b fa=%0d busy=%0b",
                          c, entry_count, free_valid, free_addr, write_busy,
                          e_count, e_free_valid, e_free_addr, e_busy);
      end
    end
    rst = 1'b0; write_enable = 1'b0; write_delete = 1'b0; compare_valid = 1'b0; age_tick = 1'b0;
  endtask

  task automatic test_aging();
    int nb, exp_nb, exp_cnt;
    logic [DW-1:0] k0, k1, k2;
    k0 = 48'h00AA_1111_0000; k1 = 48'h00BB_2222_0000; k2 = 48'h00CC_3333_0000;
`ifdef CAM_AGING_EN
    exp_nb = 32;
`else
    exp_nb = 0;
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    wr(0, k0, 1'b0);
    wr(1, k1, 1'b0);
    compare_valid = 1'b1; compare_data = k0;
    for (int s = 0; s < 2; s++) begin
      age_tick = 1'b1; tick(); age_tick = 1'b0;
      nb = 0;
      for (int c = 0; c < 64 && write_busy === 1'b1; c++) begin
        nb++;
        if (s == 1 && nb == 3) begin
          write_enable = 1'b1; write_addr = 5'd5; write_data = k2; write_delete = 1'b0;
        end
        tick();
        write_enable = 1'b0;
      end
      n_total++;
      if (nb !== exp_nb) begin n_bad++; $display("FAIL age_busy_len sweep=%0d got=%0d exp=%0d", s, nb, exp_nb); end
      tick();
`ifdef CAM_AGING_EN
      exp_cnt = (s == 0) ? 2 : 1;
`else
      exp_cnt = 2;
`endif
      n_total++;
      if (entry_count !== exp_cnt[AW:0]) begin
        n_bad++; $display("FAIL age_count sweep=%0d got=%0d exp=%0d", s, entry_count, exp_cnt);
      end
    end
    cmp(k1); tick();
    n_total++;
`ifdef CAM_AGING_EN
    if (match !== 1'b0) begin n_bad++; $display("FAIL age_evicted got m=%0b exp=0", match); end
`else
    if (match !== 1'b1 || match_addr !== 5'd1) begin
      n_bad++; $display("FAIL age_ignored got m=%0b addr=%0d exp 1/1", match, match_addr);
    end
`endif
    cmp(k0); tick();
    n_total++;
    if (match !== 1'b1 || match_addr !== 5'd0) begin
      n_bad++; $display("FAIL age_kept got m=%0b addr=%0d exp 1/0", match, match_addr);
    end
    cmp(k2); tick();
    n_total++;
    if (match_valid !== 1'b1 || match !== 1'b0) begin
      n_bad++; $display("FAIL age_write_dropped got mv=%0b m=%0b exp 1/0", match_valid, match);
    end
    age_tick = 1'b1; tick(); age_tick = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    n_total++;
    if (write_busy !== 1'b0 || entry_count !== 6'd0) begin
      n_bad++; $display("FAIL age_reset_abort got busy=%0b count=%0d exp 0/0", write_busy, entry_count);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_multi();
    test_fill();
    test_same_cycle();
    test_miss_reset();
    test_aging();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
